mem_arbiter: RTL

Single-port memory arbiter between the CPU's instruction-fetch port and data port. It lets one synchronous single-port RAM serve both `instrAddr` fetches and `dataAddr`/`writeData`/`we` accesses. Each cycle it grants exactly one requester and routes that requester's address and write data to the RAM. Read data returns one cycle later, steered to the owner with a valid strobe; the CPU side stalls on missing grant/valid. Fixed priority favours data, with a starvation bound for fetch.

---
 rtl/mem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port RAM between fetch and data ports; data wins unless fetch has waited MAX_DATA_RUN grants.
// Grant is combinational (0 cycles), read data returns 1 cycle later with a valid strobe; losers stall by holding their request.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iGnt,
  output logic              iValid,
  output logic [DATA_W-1:0] iData,
  input  logic              dReq,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic              dWe,
  input  logic [DATA_W-1:0] dWriteData,
  output logic              dGnt,
  output logic              dValid,
  output logic [DATA_W-1:0] dReadData,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-3:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  logic [3:0] run_cnt_q, run_cnt_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       i_gnt, d_gnt, run_full;

  // Byte-lane bits are deliberately dropped; no misalignment handling.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{iAddr[1:0], dAddr[1:0]};

  assign run_full = (run_cnt_q == RUN_MAX);

  always_comb begin
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    run_cnt_d  = 4'd0;
    rd_owner_d = OWN_NONE;
    // Grants are forced low while reset is held, independent of the clock.
    if (n_reset) begin
      if (iReq && (!dReq || run_full)) begin
        i_gnt = 1'b1;
      end else if (dReq) begin
        d_gnt = 1'b1;
      end
    end
    if (d_gnt && iReq && !run_full) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
    if (i_gnt) begin
      rd_owner_d = OWN_I;
    end else if (d_gnt && !dWe) begin
      rd_owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      run_cnt_q  <= 4'd0;
      rd_owner_q <= OWN_NONE;
    end else begin
      run_cnt_q  <= run_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    iGnt         = i_gnt;
    dGnt         = d_gnt;
    memEn        = i_gnt | d_gnt;
    memWe        = d_gnt & dWe;
    memAddr      = '0;
    memWriteData = '0;
    if (i_gnt) begin
      memAddr = iAddr[ADDR_W-1:2];
    end else if (d_gnt) begin
      memAddr      = dAddr[ADDR_W-1:2];
      memWriteData = dWriteData;
    end
    iValid    = (rd_owner_q == OWN_I);
    dValid    = (rd_owner_q == OWN_D);
    iData     = iValid ? memReadData : '0;
    dReadData = dValid ? memReadData : '0;
  end

endmodule
